// File: rtl/time_setter_pkg.sv
// Shared definitions for the time/date/alarm editor: state and field codes,
// word layouts of the core's time/date/alarm buses, and per-field limits.
package time_setter_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_EDIT_TIME  = 2'd1;
    localparam logic [1:0] ST_COMMIT     = 2'd2;
    localparam logic [1:0] ST_EDIT_ALARM = 2'd3;

    localparam logic [2:0] FLD_YEAR  = 3'd0;
    localparam logic [2:0] FLD_MONTH = 3'd1;
    localparam logic [2:0] FLD_DAY   = 3'd2;
    localparam logic [2:0] FLD_HOUR  = 3'd3;
    localparam logic [2:0] FLD_MIN   = 3'd4;
    localparam logic [2:0] FLD_SEC   = 3'd5;

    localparam logic [2:0] FLD_A_HOUR = 3'd0;
    localparam logic [2:0] FLD_A_MIN  = 3'd1;
    localparam logic [2:0] FLD_A_SEC  = 3'd2;

    localparam int TIME_MER_BIT   = 17;
    localparam int TIME_HOUR_LSB  = 12;
    localparam int TIME_MIN_LSB   = 6;
    localparam int TIME_SEC_LSB   = 0;
    localparam int DATE_YEAR_LSB  = 9;
    localparam int DATE_MONTH_LSB = 5;
    localparam int DATE_DAY_LSB   = 0;
    localparam int ALARM_HOUR_LSB = 12;
    localparam int ALARM_MIN_LSB  = 6;
    localparam int ALARM_SEC_LSB  = 0;

    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int YEAR_W  = 7;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int VAL_W   = 7;

    localparam logic [6:0] LIM_ZERO  = 7'd0;
    localparam logic [6:0] SEC_MAX   = 7'd59;
    localparam logic [6:0] MIN_MAX   = 7'd59;
    localparam logic [6:0] HOUR_MAX  = 7'd23;
    localparam logic [6:0] YEAR_MAX  = 7'd99;
    localparam logic [6:0] MONTH_MIN = 7'd1;
    localparam logic [6:0] MONTH_MAX = 7'd12;
    localparam logic [6:0] DAY_MIN   = 7'd1;
    localparam logic [6:0] DAY_MAX   = 7'd31;

    localparam logic [15:0] RESET_DATE = {7'd16, 4'd1, 5'd1};

    typedef struct packed {
        logic [6:0] val;
        logic [6:0] lo;
        logic [6:0] hi;
    } field_sel_t;

    function automatic logic is_pm(input logic [4:0] hour);
        return hour >= 5'd12;
    endfunction

endpackage

// File: rtl/time_setter_field_stepper.sv
// Steps one field value up or down by one, wrapping inside [min_val, max_val].
module time_setter_field_stepper (
    input  logic [6:0] value,
    input  logic [6:0] min_val,
    input  logic [6:0] max_val,
    input  logic       up,
    input  logic       down,
    output logic [6:0] next_val
);

    logic [6:0] base;

    // Out-of-range captured values are pulled to the minimum before the step applies.
    always_comb begin
        base     = (value < min_val || value > max_val) ? min_val : value;
        next_val = base;
        if (up && !down) begin
            next_val = (base == max_val) ? min_val : base + 7'd1;
        end else if (down && !up) begin
            next_val = (base == min_val) ? max_val : base - 7'd1;
        end
    end

endmodule

// File: rtl/time_setter.sv
// Button-driven editor for the core's time, date and alarm images, including
// the SETTING/SETTING_OK commit handshake and inactivity abandon.
module time_setter
    import time_setter_pkg::*;
#(
    parameter int EXIT_CYC    = 30000,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        BTN_MODE,
    input  logic        BTN_NEXT,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic [17:0] CUR_TIME,
    input  logic [15:0] CUR_DATE,
    input  logic [16:0] CUR_ALARM,
    input  logic        SETTING_OK,
    output logic        MODE,
    output logic        MODE_STATE,
    output logic        SETTING,
    output logic [17:0] SET_TIME,
    output logic [15:0] SET_DATE,
    output logic [16:0] SET_ALARM,
    output logic [2:0]  FIELD,
    output logic        ERR
);

    localparam int IDLE_W = $clog2(EXIT_CYC + 1);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(EXIT_CYC - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

    logic [1:0]        state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [ACK_W-1:0]  ack_cnt;
    field_sel_t        sel;
    logic [6:0]        fld_next;
    logic              any_btn;
    logic              step_act;
    logic              unused_cur_meridian;

    assign unused_cur_meridian = CUR_TIME[TIME_MER_BIT];
    assign any_btn  = BTN_MODE | BTN_NEXT | BTN_UP | BTN_DOWN;
    assign step_act = (BTN_UP ^ BTN_DOWN) & ~BTN_MODE & ~BTN_NEXT;

    // Route the field under the cursor, with its limits, to the single stepper.
    always_comb begin
        sel = '0;
        if (state == ST_EDIT_ALARM) begin
            case (FIELD)
                FLD_A_HOUR: sel = '{VAL_W'(SET_ALARM[ALARM_HOUR_LSB +: HOUR_W]), LIM_ZERO, HOUR_MAX};
                FLD_A_MIN:  sel = '{VAL_W'(SET_ALARM[ALARM_MIN_LSB +: MIN_W]), LIM_ZERO, MIN_MAX};
                FLD_A_SEC:  sel = '{VAL_W'(SET_ALARM[ALARM_SEC_LSB +: SEC_W]), LIM_ZERO, SEC_MAX};
                default:    sel = '0;
            endcase
        end else begin
            case (FIELD)
                FLD_YEAR:  sel = '{VAL_W'(SET_DATE[DATE_YEAR_LSB +: YEAR_W]), LIM_ZERO, YEAR_MAX};
                FLD_MONTH: sel = '{VAL_W'(SET_DATE[DATE_MONTH_LSB +: MONTH_W]), MONTH_MIN, MONTH_MAX};
                FLD_DAY:   sel = '{VAL_W'(SET_DATE[DATE_DAY_LSB +: DAY_W]), DAY_MIN, DAY_MAX};
                FLD_HOUR:  sel = '{VAL_W'(SET_TIME[TIME_HOUR_LSB +: HOUR_W]), LIM_ZERO, HOUR_MAX};
                FLD_MIN:   sel = '{VAL_W'(SET_TIME[TIME_MIN_LSB +: MIN_W]), LIM_ZERO, MIN_MAX};
                FLD_SEC:   sel = '{VAL_W'(SET_TIME[TIME_SEC_LSB +: SEC_W]), LIM_ZERO, SEC_MAX};
                default:   sel = '0;
            endcase
        end
    end

    time_setter_field_stepper u_stepper (
        .value    (sel.val),
        .min_val  (sel.lo),
        .max_val  (sel.hi),
        .up       (BTN_UP),
        .down     (BTN_DOWN),
        .next_val (fld_next)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            MODE       <= 1'b0;
            MODE_STATE <= 1'b0;
            SETTING    <= 1'b0;
            FIELD      <= '0;
            ERR        <= 1'b0;
            SET_TIME   <= '0;
            SET_DATE   <= RESET_DATE;
            SET_ALARM  <= '0;
            idle_cnt   <= '0;
            ack_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (BTN_MODE) begin
                        state    <= ST_EDIT_TIME;
                        MODE     <= 1'b1;
                        FIELD    <= FLD_YEAR;
                        ERR      <= 1'b0;
                        SET_TIME <= {is_pm(CUR_TIME[TIME_HOUR_LSB +: HOUR_W]), CUR_TIME[16:0]};
                        SET_DATE <= CUR_DATE;
                        idle_cnt <= '0;
                    end
                end
                ST_EDIT_TIME: begin
                    idle_cnt <= any_btn ? '0 : idle_cnt + IDLE_W'(1);
                    if (BTN_MODE) begin
                        state   <= ST_COMMIT;
                        SETTING <= 1'b1;
                        ack_cnt <= '0;
                    end else if (BTN_NEXT) begin
                        FIELD <= (FIELD == FLD_SEC) ? FLD_YEAR : FIELD + 3'd1;
                    end else if (step_act) begin
                        case (FIELD)
                            FLD_YEAR:  SET_DATE[DATE_YEAR_LSB +: YEAR_W]   <= fld_next[YEAR_W-1:0];
                            FLD_MONTH: SET_DATE[DATE_MONTH_LSB +: MONTH_W] <= fld_next[MONTH_W-1:0];
                            FLD_DAY:   SET_DATE[DATE_DAY_LSB +: DAY_W]     <= fld_next[DAY_W-1:0];
                            FLD_HOUR: begin
                                SET_TIME[TIME_HOUR_LSB +: HOUR_W] <= fld_next[HOUR_W-1:0];
                                SET_TIME[TIME_MER_BIT]            <= is_pm(fld_next[HOUR_W-1:0]);
                            end
                            FLD_MIN:   SET_TIME[TIME_MIN_LSB +: MIN_W] <= fld_next[MIN_W-1:0];
                            FLD_SEC:   SET_TIME[TIME_SEC_LSB +: SEC_W] <= fld_next[SEC_W-1:0];
                            default: ;
                        endcase
                    end else if (!any_btn && idle_cnt == IDLE_LAST) begin
                        state <= ST_IDLE;
                        MODE  <= 1'b0;
                        FIELD <= '0;
                    end
                end
                // A missing acknowledge still moves on to the alarm page, flagging ERR.
                ST_COMMIT: begin
                    if (SETTING_OK || ack_cnt == ACK_LAST) begin
                        state      <= ST_EDIT_ALARM;
                        SETTING    <= 1'b0;
                        MODE_STATE <= 1'b1;
                        SET_ALARM  <= CUR_ALARM;
                        FIELD      <= FLD_A_HOUR;
                        idle_cnt   <= '0;
                        if (!SETTING_OK) begin
                            ERR <= 1'b1;
                        end
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                ST_EDIT_ALARM: begin
                    idle_cnt <= any_btn ? '0 : idle_cnt + IDLE_W'(1);
                    if (BTN_MODE || (!any_btn && idle_cnt == IDLE_LAST)) begin
                        state      <= ST_IDLE;
                        MODE       <= 1'b0;
                        MODE_STATE <= 1'b0;
                        FIELD      <= '0;
                    end else if (BTN_NEXT) begin
                        FIELD <= (FIELD == FLD_A_SEC) ? FLD_A_HOUR : FIELD + 3'd1;
                    end else if (step_act) begin
                        case (FIELD)
                            FLD_A_HOUR: SET_ALARM[ALARM_HOUR_LSB +: HOUR_W] <= fld_next[HOUR_W-1:0];
                            FLD_A_MIN:  SET_ALARM[ALARM_MIN_LSB +: MIN_W]   <= fld_next[MIN_W-1:0];
                            FLD_A_SEC:  SET_ALARM[ALARM_SEC_LSB +: SEC_W]   <= fld_next[SEC_W-1:0];
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
